// File: rtl/sr_arb_pkg.sv
// Shared definitions for the SR flip-flop access arbiter.
//   state_e  : arbiter FSM states (2-bit encoding)
//   OP_CLR / OP_SET : meaning of a requester's op_set bit
//   MAX_REQ / MAX_HOLD : supported limits for NUM_REQ and HOLD_CYCLES
//   idx_width() : width of an index into a NUM_REQ-wide vector (min 1)
package sr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic OP_CLR = 1'b0;
  localparam logic OP_SET = 1'b1;

  localparam int MAX_REQ  = 8;
  localparam int MAX_HOLD = 15;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sr_access_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Scans req upward starting at ptr, wrapping from NUM_REQ-1 back to 0,
// and reports the first requester found.
//   req        in   NUM_REQ  request levels
//   ptr        in   IDX_W    index with highest priority this round
//   win_onehot out  NUM_REQ  one-hot winner (0 when no request)
//   win_idx    out  IDX_W    index of the winner
//   valid      out  1        at least one request pending
module rr_pick
  import sr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0]   win_idx,
  output logic               valid
);

  logic             found;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  // One extra bit on sum lets ptr+i exceed NUM_REQ-1 before the wrap.
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    found      = 1'b0;
    sum        = '0;
    idx        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      idx = sum[IDX_W-1:0];
      if (!found && req[idx]) begin
        found           = 1'b1;
        win_onehot[idx] = 1'b1;
        win_idx         = idx;
      end
    end
    valid = |req;
  end

endmodule

// File: rtl/sr_access_arbiter.sv
// Shares one clocked SR flip-flop among NUM_REQ requesters.
// One pending request is chosen round-robin, its set/clear is driven onto the
// flop for a single cycle, the flop is then left idle for HOLD_CYCLES, and a
// done pulse closes the operation.
//   clock, reset   posedge clock, synchronous active-high reset
//   req, op_set    per-requester request level and set(1)/clear(0) selector
//   q_in           current q of the shared flop (readback)
//   gnt            one-hot grant pulse during the drive cycle
//   s, r, enable   flop controls; enable is active-low
//   busy, done     not-idle indicator and one-cycle completion pulse
//   err            one-cycle readback-mismatch pulse alongside done
// Optional feature: define SR_READBACK_CHECK_EN to compare q_in against the
// requested value in the DONE cycle; otherwise err is constant 0.
module sr_access_arbiter
  import sr_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] op_set,
  input  logic               q_in,
  output logic [NUM_REQ-1:0] gnt,
  output logic               s,
  output logic               r,
  output logic               enable,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int               IDX_W     = idx_width(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [3:0]       HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   w_oh_q, w_oh_d;
  logic                 exp_q, exp_d;
  logic [3:0]           cnt_q, cnt_d;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req),
    .ptr        (ptr_q),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .valid      (pick_valid)
  );

  // The winner and its requested value are captured on the grant edge, so
  // later changes on req/op_set cannot disturb an operation in flight.
  // The pointer moves only when a grant is made.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    w_oh_d  = w_oh_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = DRIVE;
          w_oh_d  = pick_onehot;
          exp_d   = op_set[pick_idx];
          ptr_d   = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
          cnt_d   = '0;
        end
      end
      DRIVE: state_d = HOLD;
      HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HOLD_LAST) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      w_oh_q  <= '0;
      exp_q   <= OP_CLR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      w_oh_q  <= w_oh_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode the current state only; s and r are gated by the same
  // DRIVE term with opposite polarities of exp_q, so they can never both be 1.
  always_comb begin
    gnt    = (state_q == DRIVE) ? w_oh_q : '0;
    s      = (state_q == DRIVE) &&  exp_q;
    r      = (state_q == DRIVE) && !exp_q;
    enable = (state_q != DRIVE);
    busy   = (state_q != IDLE);
    done   = (state_q == DONE);
  end

`ifdef SR_READBACK_CHECK_EN
  assign err = (state_q == DONE) && (q_in != exp_q);
`else
  logic unused_q_in;
  assign unused_q_in = q_in;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sr_access_arbiter.sv
// Scoreboard bench for sr_access_arbiter with a behavioural SR flop attached.
// Stimulus pushes expected grants; a negedge monitor pops them when gnt or
// done appears and compares timing, flop controls, err and the flop readback.
module tb_sr_access_arbiter;

  localparam int NUM_REQ = 4;
  localparam int HOLD    = 2;
`ifdef SR_READBACK_CHECK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [NUM_REQ-1:0] req = '0;
  logic [NUM_REQ-1:0] op_set = '0;
  logic               q_in;
  logic [NUM_REQ-1:0] gnt;
  logic               s, r, enable, busy, done, err;

  sr_access_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .op_set (op_set),
    .q_in   (q_in),
    .gnt    (gnt),
    .s      (s),
    .r      (r),
    .enable (enable),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural srff: updates only while enable is low; force_q0 corrupts the readback.
  logic q_ff = 1'b0;
  logic force_q0 = 1'b0;
  always @(posedge clock) begin
    if (enable === 1'b0) begin
      if (s) q_ff <= 1'b1;
      else if (r) q_ff <= 1'b0;
    end
  end
  assign q_in = force_q0 ? 1'b0 : q_ff;

  typedef struct {
    logic [NUM_REQ-1:0] gnt;
    logic               s;
    logic               r;
    int                 cyc;
    logic               exp_err;
    logic               exp_q;
  } gnt_rec_t;

  typedef struct {
    int   cyc;
    logic exp_err;
    logic exp_q;
  } done_rec_t;

  gnt_rec_t  gq[$];
  done_rec_t dq[$];
  gnt_rec_t  grec;
  done_rec_t drec;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: every grant must match the head of the grant queue; each grant
  // schedules a done HOLD+1 cycles later carrying the expected err/readback.
  always @(negedge clock) begin
    if (!reset && mon_en) begin
      checkOutput("s_r_exclusive", 32'(s & r), 32'd0);
      if (gnt != '0) begin
        if (gq.size() == 0) begin
          checkOutput("unexpected_gnt", 32'(gnt), 32'd0);
        end else begin
          grec = gq.pop_front();
          checkOutput("gnt_value", 32'(gnt), 32'(grec.gnt));
          checkOutput("gnt_s", 32'(s), 32'(grec.s));
          checkOutput("gnt_r", 32'(r), 32'(grec.r));
          checkOutput("gnt_enable", 32'(enable), 32'd0);
          checkOutput("gnt_busy", 32'(busy), 32'd1);
          checkOutput("gnt_cycle", 32'(cyc), 32'(grec.cyc));
          drec.cyc     = grec.cyc + HOLD + 1;
          drec.exp_err = grec.exp_err;
          drec.exp_q   = grec.exp_q;
          dq.push_back(drec);
        end
      end else begin
        checkOutput("idle_s", 32'(s), 32'd0);
        checkOutput("idle_r", 32'(r), 32'd0);
      end
      if (done) begin
        if (dq.size() == 0) begin
          checkOutput("unexpected_done", 32'(done), 32'd0);
        end else begin
          drec = dq.pop_front();
          checkOutput("done_cycle", 32'(cyc), 32'(drec.cyc));
          checkOutput("done_err", 32'(err), 32'(drec.exp_err));
          checkOutput("done_q_in", 32'(q_in), 32'(drec.exp_q));
        end
      end else begin
        checkOutput("err_outside_done", 32'(err), 32'd0);
      end
    end
  end

  function automatic gnt_rec_t mkRec(input int w, input logic op, input int at, input logic forced);
    gnt_rec_t rr;
    rr.gnt     = '0;
    rr.gnt[w]  = 1'b1;
    rr.s       = op;
    rr.r       = ~op;
    rr.cyc     = at;
    rr.exp_err = RB_EN && forced && op;
    rr.exp_q   = forced ? 1'b0 : op;
    return rr;
  endfunction

  // One complete operation for a lone requester, starting and ending in IDLE.
  task automatic applyStimulus(input int idx, input logic op, input logic forced);
    op_set      = op ? '0 : '1;
    op_set[idx] = op;
    req         = '0;
    req[idx]    = 1'b1;
    force_q0    = forced;
    gq.push_back(mkRec(idx, op, cyc + 1, forced));
    @(negedge clock);
    req = '0;
    repeat (HOLD + 2) @(negedge clock);
    force_q0 = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clock);
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_s", 32'(s), 32'd0);
    checkOutput("rst_r", 32'(r), 32'd0);
    checkOutput("rst_enable", 32'(enable), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Single set by requester 2
    applyStimulus(2, 1'b1, 1'b0);

    // Reset held two cycles from inside HOLD abandons the operation
    op_set = 4'b0000;
    req    = 4'b0001;
    gq.push_back(mkRec(0, 1'b0, cyc + 1, 1'b0));
    @(negedge clock);
    req = '0;
    @(negedge clock);
    checkOutput("mid_hold_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    dq.delete();
    @(negedge clock);
    checkOutput("rst2_gnt", 32'(gnt), 32'd0);
    checkOutput("rst2_enable", 32'(enable), 32'd1);
    checkOutput("rst2_busy", 32'(busy), 32'd0);
    checkOutput("rst2_s", 32'(s), 32'd0);
    checkOutput("rst2_r", 32'(r), 32'd0);
    checkOutput("rst2_done", 32'(done), 32'd0);
    @(negedge clock);
    checkOutput("rst2_done_b", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // Round-robin with all requests held, pointer back at 0 after reset
    op_set = 4'b0101;
    req    = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      gq.push_back(mkRec(k % 4, op_set[k % 4], cyc + 1 + k * (HOLD + 3), 1'b0));
    end
    repeat (1 + 4 * (HOLD + 3)) @(negedge clock);
    req = '0;
    repeat (HOLD + 2) @(negedge clock);

    // Requester 1 appears during requester 0's operation and withdraws
    op_set = 4'b0001;
    req    = 4'b0001;
    gq.push_back(mkRec(0, 1'b1, cyc + 1, 1'b0));
    @(negedge clock);
    req = 4'b0010;
    @(negedge clock);
    req = 4'b0000;
    repeat (6) @(negedge clock);

    // Clear path: set by 0, then clear by 3
    applyStimulus(0, 1'b1, 1'b0);
    applyStimulus(3, 1'b0, 1'b0);

    // Readback forced low during a set
    applyStimulus(2, 1'b1, 1'b1);

    // Wrap: ptr is 3, requesters 3 and 0 pending
    op_set = 4'b0001;
    req    = 4'b1001;
    gq.push_back(mkRec(3, 1'b0, cyc + 1, 1'b0));
    gq.push_back(mkRec(0, 1'b1, cyc + 1 + (HOLD + 3), 1'b0));
    @(negedge clock);
    req = 4'b0001;
    repeat (HOLD + 3) @(negedge clock);
    req = '0;
    repeat (HOLD + 4) @(negedge clock);

    checkOutput("sb_gnt_empty", 32'(gq.size()), 32'd0);
    checkOutput("sb_done_empty", 32'(dq.size()), 32'd0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
